// File: rtl/iir_coef_sequencer.sv
// rtl/iir_coef_sequencer.sv - IIR run-time controller: shadow coefficient banks, drain-and-swap commit, aligned out_valid
//
// Purpose:
//   Coefficient writes land in a shadow bank. A commit drains the filter with FLUSH_LEN zero
//   samples, then copies the shadow banks into the active coefsA/coefsB buses. No result is
//   therefore ever computed from a mix of old and new coefficients. A shift register that
//   matches the filter latency turns accepted samples into out_valid.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cfg_valid/cfg_ready      coefficient write handshake (cfg_bank, cfg_idx, cfg_data)
//   cfg_commit               one-cycle pulse that requests a bank swap
//   cfg_err                  one-cycle pulse after a write with an out-of-range index
//   busy                     a commit is in progress
//   s_valid/s_ready/s_data   input sample stream
//   filt_in                  registered sample to the filter (zero when idle)
//   coefsA, coefsB           active banks; tap i at [(N-1-i)*32 +: 32]
//   filt_out                 filter result
//   out_valid, out_data      out_data passes filt_out through; out_valid marks results of accepted samples
module iir_coef_sequencer #(
    parameter int INPUT_SZ  = 16,
    parameter int RESULT_SZ = 33,
    parameter int REGSA_NUM = 2,
    parameter int REGSB_NUM = 2,
    parameter int PIPE_LAT  = 3,
    parameter int FLUSH_LEN = REGSA_NUM + PIPE_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   cfg_bank,
    input  logic [7:0]             cfg_idx,
    input  logic [31:0]            cfg_data,
    input  logic                   cfg_commit,
    output logic                   cfg_err,
    output logic                   busy,
    input  logic                   s_valid,
    input  logic [INPUT_SZ-1:0]    s_data,
    output logic                   s_ready,
    output logic [INPUT_SZ-1:0]    filt_in,
    output logic [REGSA_NUM*32-1:0] coefsA,
    output logic [REGSB_NUM*32-1:0] coefsB,
    input  logic [RESULT_SZ-1:0]   filt_out,
    output logic                   out_valid,
    output logic [RESULT_SZ-1:0]   out_data
);

    localparam int CNT_W = $clog2(FLUSH_LEN) + 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SWAP  = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [REGSA_NUM*32-1:0] shad_a_q, shad_a_d, act_a_q, act_a_d;
    logic [REGSB_NUM*32-1:0] shad_b_q, shad_b_d, act_b_q, act_b_d;
    logic [INPUT_SZ-1:0]     filt_in_q, filt_in_d;
    logic [PIPE_LAT-1:0]     vpipe_q, vpipe_d;
    logic                    err_q, err_d;

    logic cfg_wr, idx_ok, s_accept;

    assign s_ready   = (state_q == ST_RUN) & ~rst;
    assign cfg_ready = (state_q != ST_SWAP) & ~rst;
    assign cfg_wr    = cfg_valid & cfg_ready;
    assign s_accept  = s_valid & s_ready;
    assign idx_ok    = cfg_bank ? (cfg_idx < 8'(REGSB_NUM)) : (cfg_idx < 8'(REGSA_NUM));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shad_a_d  = shad_a_q;
        shad_b_d  = shad_b_q;
        act_a_d   = act_a_q;
        act_b_d   = act_b_q;
        filt_in_d = s_accept ? s_data : '0;
        vpipe_d   = (vpipe_q << 1) | PIPE_LAT'(s_accept);
        err_d     = cfg_wr & ~idx_ok;

        if (cfg_wr) begin
            for (int i = 0; i < REGSA_NUM; i++) begin
                if (!cfg_bank && cfg_idx == 8'(i)) begin
                    shad_a_d[(REGSA_NUM-1-i)*32 +: 32] = cfg_data;
                end
            end
            for (int i = 0; i < REGSB_NUM; i++) begin
                if (cfg_bank && cfg_idx == 8'(i)) begin
                    shad_b_d[(REGSB_NUM-1-i)*32 +: 32] = cfg_data;
                end
            end
        end

        case (state_q)
            ST_RUN: begin
                if (cfg_commit) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(FLUSH_LEN - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    // Load from the next-state shadow so a write in the last
                    // drain cycle still makes it into this swap; the new
                    // coefficients are visible throughout the SWAP cycle.
                    state_d = ST_SWAP;
                    act_a_d = shad_a_d;
                    act_b_d = shad_b_d;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SWAP: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            shad_a_q  <= '0;
            shad_b_q  <= '0;
            act_a_q   <= '0;
            act_b_q   <= '0;
            filt_in_q <= '0;
            vpipe_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shad_a_q  <= shad_a_d;
            shad_b_q  <= shad_b_d;
            act_a_q   <= act_a_d;
            act_b_q   <= act_b_d;
            filt_in_q <= filt_in_d;
            vpipe_q   <= vpipe_d;
            err_q     <= err_d;
        end
    end

    assign coefsA    = act_a_q;
    assign coefsB    = act_b_q;
    assign filt_in   = filt_in_q;
    assign out_valid = vpipe_q[PIPE_LAT-1];
    assign out_data  = filt_out;
    assign cfg_err   = err_q;
    assign busy      = (state_q != ST_RUN);

endmodule

// File: tb/tb_iir_coef_sequencer.sv
// tb/tb_iir_coef_sequencer.sv - directed self-checking bench for iir_coef_sequencer
module tb_iir_coef_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready, cfg_bank, cfg_commit, cfg_err, busy;
    logic [7:0]  cfg_idx;
    logic [31:0] cfg_data;
    logic        s_valid, s_ready, out_valid;
    logic [15:0] s_data, filt_in;
    logic [63:0] coefsA, coefsB;
    logic [32:0] filt_out, out_data;

    int nerr = 0;
    int nchk = 0;

    iir_coef_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bank(cfg_bank),
        .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cfg_err(cfg_err), .busy(busy),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .filt_in(filt_in), .coefsA(coefsA), .coefsB(coefsB),
        .filt_out(filt_out), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    localparam logic [63:0] A_NEW  = 64'h00004000_00002000;
    localparam logic [63:0] A_NEW2 = 64'h00007777_00002000;
    localparam logic [63:0] B_NEW  = 64'h00000000_00001111;

    logic [10:0] pat;

    initial begin
        rst = 1'b1; cfg_valid = 0; cfg_bank = 0; cfg_idx = 0; cfg_data = 0;
        cfg_commit = 0; s_valid = 0; s_data = 0; filt_out = 33'h1_2345_6789;

        // 1: reset
        tick(); tick();
        chk("rst_coefsA", coefsA, 64'h0);
        chk("rst_coefsB", coefsB, 64'h0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_s_ready", {63'h0, s_ready}, 64'h0);
        chk("rst_cfg_ready", {63'h0, cfg_ready}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_filt_in", {48'h0, filt_in}, 64'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_s_ready", {63'h0, s_ready}, 64'h1);
        chk("post_rst_busy", {63'h0, busy}, 64'h0);
        chk("passthrough", {31'h0, out_data}, 64'h1_2345_6789);

        // 2: latency, valid pattern per cycle k; out_valid(k) = pat[k-3]
        pat = 11'b000_0001_0111;
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("lat_ov_%0d", k), {63'h0, out_valid},
                {63'h0, (k >= 3) ? pat[k-3] : 1'b0});
            chk($sformatf("lat_fin_%0d", k), {48'h0, filt_in},
                {48'h0, (k >= 1 && pat[k-1]) ? 16'(k) : 16'h0});
            s_valid = pat[k];
            s_data  = 16'(k + 1);
            tick();
        end
        s_valid = 0;

        // 3: write A bank then commit with a simultaneous sample
        cfg_valid = 1; cfg_bank = 0; cfg_idx = 0; cfg_data = 32'h4000;
        tick();
        cfg_idx = 1; cfg_data = 32'h2000;
        tick();
        cfg_valid = 0;
        chk("shadow_only", coefsA, 64'h0);
        cfg_commit = 1; s_valid = 1; s_data = 16'h0007;
        chk("commit_s_ready", {63'h0, s_ready}, 64'h1);
        tick();
        cfg_commit = 0;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("drain_s_ready_%0d", k), {63'h0, s_ready}, 64'h0);
            chk($sformatf("drain_busy_%0d", k), {63'h0, busy}, 64'h1);
            chk($sformatf("drain_ov_%0d", k), {63'h0, out_valid}, {63'h0, k == 3});
            chk($sformatf("drain_fin_%0d", k), {48'h0, filt_in}, (k == 1) ? 64'h7 : 64'h0);
            chk($sformatf("drain_coefsA_%0d", k), coefsA, (k >= 6) ? A_NEW : 64'h0);
            if (k == 6) s_valid = 0;
            tick();
        end
        chk("resume_s_ready", {63'h0, s_ready}, 64'h1);
        chk("resume_busy", {63'h0, busy}, 64'h0);
        chk("resume_coefsB", coefsB, 64'h0);
        for (int k = 7; k <= 9; k++) begin
            chk($sformatf("post_swap_ov_%0d", k), {63'h0, out_valid}, 64'h0);
            tick();
        end

        // 4: out-of-range writes are dropped and flagged
        cfg_valid = 1; cfg_bank = 1; cfg_idx = 5; cfg_data = 32'hDEAD;
        tick();
        chk("err_b5", {63'h0, cfg_err}, 64'h1);
        cfg_bank = 0; cfg_idx = 2; cfg_data = 32'hBAD0;
        tick();
        chk("err_a2", {63'h0, cfg_err}, 64'h1);
        cfg_bank = 1; cfg_idx = 1; cfg_data = 32'h1111;
        tick();
        cfg_valid = 0;
        chk("ok_b1", {63'h0, cfg_err}, 64'h0);
        cfg_commit = 1;
        tick();
        cfg_commit = 0;
        repeat (5) tick();
        chk("bad_idx_coefsB", coefsB, B_NEW);
        chk("bad_idx_coefsA", coefsA, A_NEW);
        tick();
        chk("bad_idx_resume", {63'h0, busy}, 64'h0);

        // 5: commit during DRAIN ignored; DRAIN write lands in this swap
        cfg_commit = 1;
        tick();
        cfg_commit = 0;
        tick();
        cfg_commit = 1; cfg_valid = 1; cfg_bank = 0; cfg_idx = 0; cfg_data = 32'h7777;
        chk("drain_cfg_ready", {63'h0, cfg_ready}, 64'h1);
        tick();
        cfg_commit = 0; cfg_valid = 0;
        repeat (3) tick();
        chk("swap_cfg_ready", {63'h0, cfg_ready}, 64'h0);
        chk("swap_busy", {63'h0, busy}, 64'h1);
        chk("swap_coefsA", coefsA, A_NEW2);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("single_swap_busy_%0d", k), {63'h0, busy}, 64'h0);
            tick();
        end

        // 6: reset mid-DRAIN aborts the commit
        cfg_commit = 1;
        tick();
        cfg_commit = 0;
        tick();
        chk("pre_abort_busy", {63'h0, busy}, 64'h1);
        rst = 1;
        tick();
        chk("abort_busy", {63'h0, busy}, 64'h0);
        chk("abort_coefsA", coefsA, 64'h0);
        chk("abort_coefsB", coefsB, 64'h0);
        rst = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("abort_idle_busy_%0d", k), {63'h0, busy}, 64'h0);
            chk($sformatf("abort_idle_coefsA_%0d", k), coefsA, 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
